// File: rtl/sim_fetch_seq.sv
// sim_fetch_seq -- fetch-side PC sequencer placed directly upstream of sim_intf.
//
// The sequencer offers pc_try to sim_intf, which answers in the same cycle.
// Hits are queued in a small instruction FIFO for the consumer. A miss
// redirects the sequencer to the PC the ISS reports. A flush from downstream
// empties the FIFO and redirects to flush_pc.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   pc_try          PC offered to sim_intf (straight from pc_q)
//   pc_factual      ISS PC for this cycle
//   insn, miss      sim_intf answer for pc_try (insn valid when !miss)
//   flush, flush_pc downstream redirect request and its target
//   out_valid/out_ready/out_pc/out_insn   FIFO head, valid/ready handshake
//   fetch_cnt, miss_cnt                    saturating statistics counters
//   fsm_state       current FSM state (INIT=0, RUN=1, FULL=2) for observation
//
// Handshake: a head entry moves on an edge where out_valid && out_ready are
// both high; out_valid never depends on out_ready, and out_pc/out_insn are
// stable while out_valid is high and out_ready is low.

module sim_fetch_seq #(
   parameter logic [63:0] START_PC = 64'h8000_0000,
   parameter int          DEPTH    = 4,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic [63:0]      pc_try,
   input  logic [63:0]      pc_factual,
   input  logic [31:0]      insn,
   input  logic             miss,
   input  logic             flush,
   input  logic [63:0]      flush_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_pc,
   output logic [31:0]      out_insn,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic [CNT_W-1:0] miss_cnt,
   output logic [1:0]       fsm_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   typedef enum logic [1:0] {
      INIT = 2'd0,
      RUN  = 2'd1,
      FULL = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [63:0]       pc_q, pc_d;
   logic [PW-1:0]     wptr_q, rptr_q;
   logic [PW-1:0]     count, count_next;
   logic [63:0]       pc_mem   [DEPTH];
   logic [31:0]       insn_mem [DEPTH];
   logic              full;
   logic              push, pop, fifo_clr;
   logic              fetch_inc, miss_inc;
   logic [63:0]       seq_pc;
   logic [CNT_W-1:0]  fetch_cnt_q, miss_cnt_q;

   // Pointers carry one extra bit so full and empty are distinguishable.
   assign count     = wptr_q - rptr_q;
   assign full      = (count == DEPTH_P);
   assign out_valid = (count != '0);

   // Flush is honoured in RUN and FULL; INIT is a dead cycle.
   assign fifo_clr = flush && (state_q != INIT);
   // Push is gated on full-at-start-of-cycle only; a same-cycle pop does not help.
   assign push     = (state_q == RUN) && !flush && !miss && !full;
   assign pop      = out_valid && out_ready && !flush;

   assign count_next = fifo_clr ? '0
                                : count + PW'(push) - PW'(pop);

   // 32-bit instructions have low bits 2'b11; anything else is compressed.
   assign seq_pc = (insn[1:0] == 2'b11) ? pc_q + 64'd4 : pc_q + 64'd2;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      fetch_inc = 1'b0;
      miss_inc  = 1'b0;
      case (state_q)
         INIT: state_d = RUN;
         RUN: begin
            if (flush) begin
               pc_d = flush_pc;
            end else if (miss) begin
               pc_d      = pc_factual;
               fetch_inc = 1'b1;
               miss_inc  = 1'b1;
            end else if (!full) begin
               pc_d      = seq_pc;
               fetch_inc = 1'b1;
            end
            if (!flush && count_next == DEPTH_P) state_d = FULL;
         end
         FULL: begin
            if (flush) begin
               pc_d    = flush_pc;
               state_d = RUN;
            end else if (count_next < DEPTH_P) begin
               state_d = RUN;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= INIT;
         pc_q        <= START_PC;
         wptr_q      <= '0;
         rptr_q      <= '0;
         fetch_cnt_q <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (fifo_clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
         end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
         end
         // Counters stick at all-ones instead of wrapping.
         if (fetch_inc && !(&fetch_cnt_q)) fetch_cnt_q <= fetch_cnt_q + 1'b1;
         if (miss_inc  && !(&miss_cnt_q))  miss_cnt_q  <= miss_cnt_q + 1'b1;
      end
   end

   // Storage needs no reset: out_valid masks stale entries.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wptr_q[AW-1:0]]   <= pc_q;
         insn_mem[wptr_q[AW-1:0]] <= insn;
      end
   end

   // A hit in RUN with the FIFO already full must never happen: FULL is
   // entered on the edge that fills the last slot.
   always @(posedge clk) begin
      if (!rst && state_q == RUN && !flush && !miss) assert (!full);
   end

   assign pc_try    = pc_q;
   assign out_pc    = out_valid ? pc_mem[rptr_q[AW-1:0]]   : 64'd0;
   assign out_insn  = out_valid ? insn_mem[rptr_q[AW-1:0]] : 32'd0;
   assign fetch_cnt = fetch_cnt_q;
   assign miss_cnt  = miss_cnt_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_sim_fetch_seq.sv
// Directed bench for sim_fetch_seq: reset, in-order hits, miss redirect,
// FIFO fill/stall/resume, compressed and wrapping PC steps, flush priority
// over miss, and reset while FULL.

module tb_sim_fetch_seq;

  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  // clock/reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] pc_try, pc_factual, flush_pc, out_pc;
  logic [31:0] insn, out_insn, fetch_cnt, miss_cnt;
  logic        miss, flush, out_valid, out_ready;
  logic [1:0]  fsm_state;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  sim_fetch_seq #(
    .START_PC(64'h8000_0000),
    .DEPTH   (4),
    .CNT_W   (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_try    (pc_try),
    .pc_factual(pc_factual),
    .insn      (insn),
    .miss      (miss),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_insn  (out_insn),
    .fetch_cnt (fetch_cnt),
    .miss_cnt  (miss_cnt),
    .fsm_state (fsm_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [31:0] i);
    flush = 1'b0;
    miss  = 1'b0;
    insn  = i;
  endtask

  // scoreboard comparison
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    miss = 1'b0; flush = 1'b0; insn = 32'd0; pc_factual = 64'd0;
    flush_pc = 64'd0; out_ready = 1'b0;

    // reset values
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pc",    out_pc, 64'd0);
    chk("rst_insn",  64'(out_insn), 64'd0);
    chk("rst_try",   pc_try, 64'h8000_0000);
    chk("rst_fcnt",  64'(fetch_cnt), 64'd0);
    chk("rst_mcnt",  64'(miss_cnt), 64'd0);
    chk("rst_state", 64'(fsm_state), 64'(S_INIT));
    rst = 1'b0;

    // T1: three sequential hits, consumer always ready
    hit(32'h0000_0013); out_ready = 1'b1;
    tick();  // INIT -> RUN, no sample
    chk("t1_state", 64'(fsm_state), 64'(S_RUN));
    chk("t1_try0",  pc_try, 64'h8000_0000);
    chk("t1_fcnt0", 64'(fetch_cnt), 64'd0);
    chk("t1_val0",  64'(out_valid), 64'd0);
    tick();
    chk("t1_val1",  64'(out_valid), 64'd1);
    chk("t1_pc1",   out_pc, 64'h8000_0000);
    chk("t1_insn1", 64'(out_insn), 64'h13);
    chk("t1_try1",  pc_try, 64'h8000_0004);
    tick();
    chk("t1_pc2",   out_pc, 64'h8000_0004);
    tick();
    chk("t1_pc3",   out_pc, 64'h8000_0008);
    chk("t1_fcnt",  64'(fetch_cnt), 64'd3);
    chk("t1_mcnt",  64'(miss_cnt), 64'd0);

    // T2: steer to AAAA0008, then miss back to 80000008
    flush = 1'b1; flush_pc = 64'hAAAA_0008;
    tick();
    chk("t2_fl_val", 64'(out_valid), 64'd0);
    chk("t2_fl_try", pc_try, 64'hAAAA_0008);
    chk("t2_fl_cnt", 64'(fetch_cnt), 64'd3);
    flush = 1'b0; miss = 1'b1; pc_factual = 64'h8000_0008;
    tick();
    chk("t2_try",  pc_try, 64'h8000_0008);
    chk("t2_val",  64'(out_valid), 64'd0);
    chk("t2_mcnt", 64'(miss_cnt), 64'd1);
    chk("t2_fcnt", 64'(fetch_cnt), 64'd4);

    // T3: fill FIFO with consumer stalled
    hit(32'h0000_0013); out_ready = 1'b0;
    tick(); tick(); tick();
    chk("t3_state3", 64'(fsm_state), 64'(S_RUN));
    tick();
    chk("t3_state4", 64'(fsm_state), 64'(S_FULL));
    chk("t3_try4",   pc_try, 64'h8000_0018);
    chk("t3_head",   out_pc, 64'h8000_0008);
    chk("t3_fcnt4",  64'(fetch_cnt), 64'd8);
    tick();
    chk("t3_hold_st",  64'(fsm_state), 64'(S_FULL));
    chk("t3_hold_try", pc_try, 64'h8000_0018);
    chk("t3_hold_cnt", 64'(fetch_cnt), 64'd8);
    out_ready = 1'b1;
    tick();
    chk("t3_pop_st",  64'(fsm_state), 64'(S_RUN));
    chk("t3_pop_pc",  out_pc, 64'h8000_000C);
    chk("t3_pop_try", pc_try, 64'h8000_0018);
    out_ready = 1'b0;
    tick();
    chk("t3_p5_st",  64'(fsm_state), 64'(S_FULL));
    chk("t3_p5_try", pc_try, 64'h8000_001C);
    chk("t3_p5_cnt", 64'(fetch_cnt), 64'd9);

    // T4: flush out of FULL, compressed step, then 64-bit wrap
    flush = 1'b1; flush_pc = 64'h8000_0010;
    tick();
    chk("t4_fl_st",  64'(fsm_state), 64'(S_RUN));
    chk("t4_fl_val", 64'(out_valid), 64'd0);
    chk("t4_fl_try", pc_try, 64'h8000_0010);
    chk("t4_fl_cnt", 64'(fetch_cnt), 64'd9);
    hit(32'h0000_4501); out_ready = 1'b1;
    tick();
    chk("t4_c_pc",   out_pc, 64'h8000_0010);
    chk("t4_c_insn", 64'(out_insn), 64'h4501);
    chk("t4_c_try",  pc_try, 64'h8000_0012);
    chk("t4_c_cnt",  64'(fetch_cnt), 64'd10);
    flush = 1'b1; flush_pc = 64'hFFFF_FFFF_FFFF_FFFC; insn = 32'h0000_0013;
    tick();
    chk("t4_w_val0", 64'(out_valid), 64'd0);
    chk("t4_w_try0", pc_try, 64'hFFFF_FFFF_FFFF_FFFC);
    flush = 1'b0;
    tick();
    chk("t4_w_try", pc_try, 64'd0);
    chk("t4_w_pc",  out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t4_w_cnt", 64'(fetch_cnt), 64'd11);

    // T5: three entries held, flush and miss together
    out_ready = 1'b0;
    tick(); tick();
    chk("t5_pre_pc",  out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t5_pre_try", pc_try, 64'd8);
    chk("t5_pre_cnt", 64'(fetch_cnt), 64'd13);
    flush = 1'b1; flush_pc = 64'h8000_018C; miss = 1'b1; pc_factual = 64'h1234_5678;
    tick();
    chk("t5_val",  64'(out_valid), 64'd0);
    chk("t5_try",  pc_try, 64'h8000_018C);
    chk("t5_fcnt", 64'(fetch_cnt), 64'd13);
    chk("t5_mcnt", 64'(miss_cnt), 64'd1);
    chk("t5_st",   64'(fsm_state), 64'(S_RUN));

    // T6: reset pulse while FULL
    hit(32'h0000_0013);
    tick(); tick(); tick(); tick();
    chk("t6_full",  64'(fsm_state), 64'(S_FULL));
    chk("t6_fcnt",  64'(fetch_cnt), 64'd17);
    chk("t6_try",   pc_try, 64'h8000_019C);
    #1 rst = 1'b1;
    #1;
    chk("t6_r_val",  64'(out_valid), 64'd0);
    chk("t6_r_try",  pc_try, 64'h8000_0000);
    chk("t6_r_st",   64'(fsm_state), 64'(S_INIT));
    chk("t6_r_fcnt", 64'(fetch_cnt), 64'd0);
    chk("t6_r_mcnt", 64'(miss_cnt), 64'd0);
    #1 rst = 1'b0;
    tick();
    chk("t6_i_st",   64'(fsm_state), 64'(S_RUN));
    chk("t6_i_val",  64'(out_valid), 64'd0);
    chk("t6_i_try",  pc_try, 64'h8000_0000);
    chk("t6_i_fcnt", 64'(fetch_cnt), 64'd0);
    tick();
    chk("t6_h_val",  64'(out_valid), 64'd1);
    chk("t6_h_pc",   out_pc, 64'h8000_0000);
    chk("t6_h_fcnt", 64'(fetch_cnt), 64'd1);

    // final report
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
